bs_price: RTL

- Final stage of the Black-Scholes pipeline, directly downstream of the N(d1)/N(d2) CDF stage.
- Consumes S, K, discount factor D = e^(-rT), Nd1 and Nd2, all signed fixed point.
- Produces the European call price C = S·Nd1 − K·D·Nd2 and, via put-call parity, the put price P = C − S + K·D.
- Uses one shared signed multiplier, time-multiplexed by a small FSM, with a start/done handshake matching the CDF stage.

---
 rtl/bs_price_if.sv | 26 ++
 rtl/bs_price.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bs_price_if.sv
// Handshake and data bundle between the CDF stage and the Black-Scholes pricing stage.
// The master side drives a job (start plus operands); the slave side returns prices and status.
interface bs_price_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] disc;
  logic [WIDTH-1:0] nd1;
  logic [WIDTH-1:0] nd2;
  logic [WIDTH-1:0] call;
  logic [WIDTH-1:0] put;
  logic             busy;
  logic             done;

  modport master (
    output start, s, k, disc, nd1, nd2,
    input  call, put, busy, done
  );

  modport slave (
    input  start, s, k, disc, nd1, nd2,
    output call, put, busy, done
  );
endinterface

// File: rtl/bs_price.sv
// Black-Scholes final stage: C = S*Nd1 - K*D*Nd2 and P = C - S + K*D on one shared fixed-point multiplier.
// Optional macro BS_PRICE_CLAMP_EN forces negative call/put results to zero after saturation.
module bs_price #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic        clk,
  input  logic        reset,
  bs_price_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    MUL_SN1,
    MUL_KD,
    MUL_KDN2,
    FINAL
  } state_t;

  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  // Value fits in WIDTH bits only when every bit above the result sign bit is a copy of it.
  function automatic logic [WIDTH-1:0] sat(input logic [2*WIDTH-1:0] x);
    logic [WIDTH:0] hi;
    hi = x[2*WIDTH-1:WIDTH-1];
    if (hi == '0 || hi == '1) sat = x[WIDTH-1:0];
    else if (x[2*WIDTH-1])    sat = MIN_VAL;
    else                      sat = MAX_VAL;
  endfunction

  state_t state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d, k_q, k_d, disc_q, disc_d, nd1_q, nd1_d, nd2_q, nd2_d;
  logic [WIDTH-1:0] sn1_q, sn1_d, kd_q, kd_d, kdn2_q, kdn2_d;
  logic [WIDTH-1:0] call_q, call_d, put_q, put_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0]          mul_a, mul_b;
  logic signed [2*WIDTH-1:0] mul_a_ext, mul_b_ext, prod, prod_sh;
  logic [WIDTH-1:0]          mul_res;

  logic signed [WIDTH+1:0] c_full, p_full;
  logic [WIDTH-1:0]        call_sat, put_sat, call_out, put_out;

  // Operand mux in front of the single multiplier, steered by the current multiply state.
  always_comb begin
    mul_a = s_q;
    mul_b = nd1_q;
    case (state_q)
      MUL_KD: begin
        mul_a = k_q;
        mul_b = disc_q;
      end
      MUL_KDN2: begin
        mul_a = kd_q;
        mul_b = nd2_q;
      end
      default: ;
    endcase
  end

  assign mul_a_ext = {{WIDTH{mul_a[WIDTH-1]}}, mul_a};
  assign mul_b_ext = {{WIDTH{mul_b[WIDTH-1]}}, mul_b};
  assign prod      = mul_a_ext * mul_b_ext;
  assign prod_sh   = prod >>> FRAC;
  assign mul_res   = sat(prod_sh);

  // Two guard bits keep the difference and the parity sum exact before saturation.
  assign c_full = {{2{sn1_q[WIDTH-1]}}, sn1_q} - {{2{kdn2_q[WIDTH-1]}}, kdn2_q};
  assign p_full = c_full - {{2{s_q[WIDTH-1]}}, s_q} + {{2{kd_q[WIDTH-1]}}, kd_q};

  assign call_sat = sat({{(WIDTH-2){c_full[WIDTH+1]}}, c_full});
  assign put_sat  = sat({{(WIDTH-2){p_full[WIDTH+1]}}, p_full});

`ifdef BS_PRICE_CLAMP_EN
  assign call_out = call_sat[WIDTH-1] ? '0 : call_sat;
  assign put_out  = put_sat[WIDTH-1]  ? '0 : put_sat;
`else
  assign call_out = call_sat;
  assign put_out  = put_sat;
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    disc_d  = disc_q;
    nd1_d   = nd1_q;
    nd2_d   = nd2_q;
    sn1_d   = sn1_q;
    kd_d    = kd_q;
    kdn2_d  = kdn2_q;
    call_d  = call_q;
    put_d   = put_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          s_d     = bus.s;
          k_d     = bus.k;
          disc_d  = bus.disc;
          nd1_d   = bus.nd1;
          nd2_d   = bus.nd2;
          state_d = MUL_SN1;
        end
      end
      MUL_SN1: begin
        sn1_d   = mul_res;
        state_d = MUL_KD;
      end
      MUL_KD: begin
        kd_d    = mul_res;
        state_d = MUL_KDN2;
      end
      MUL_KDN2: begin
        kdn2_d  = mul_res;
        state_d = FINAL;
      end
      FINAL: begin
        call_d  = call_out;
        put_d   = put_out;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      disc_q  <= '0;
      nd1_q   <= '0;
      nd2_q   <= '0;
      sn1_q   <= '0;
      kd_q    <= '0;
      kdn2_q  <= '0;
      call_q  <= '0;
      put_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      disc_q  <= disc_d;
      nd1_q   <= nd1_d;
      nd2_q   <= nd2_d;
      sn1_q   <= sn1_d;
      kd_q    <= kd_d;
      kdn2_q  <= kdn2_d;
      call_q  <= call_d;
      put_q   <= put_d;
      done_q  <= done_d;
    end
  end

  assign bus.call = call_q;
  assign bus.put  = put_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;

endmodule
